// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Mult/div run for a fixed number of Busy cycles, then commit HI/LO in one edge.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        HILOSel,
  output logic        Busy,
  output logic [31:0] DOut
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, MULT, DIV} state_t;

  state_t          state_reg;
  logic [CW-1:0]   count_reg;
  logic [31:0]     hi_reg;
  logic [31:0]     lo_reg;
  logic [31:0]     a_reg;
  logic [31:0]     b_reg;
  logic            signed_reg;
  logic            busy_reg;

  logic [63:0]     prod_s;
  logic [63:0]     prod_u;
  logic [63:0]     prod;
  logic            a_neg;
  logic            b_neg;
  logic [31:0]     a_mag;
  logic [31:0]     b_mag;
  logic [31:0]     b_div;
  logic [31:0]     q_mag;
  logic [31:0]     r_mag;
  logic [31:0]     quot;
  logic [31:0]     rem;

  // Low 64 bits of the product of sign-extended operands equal the signed product.
  always_comb begin
    prod_s = {{32{a_reg[31]}}, a_reg} * {{32{b_reg[31]}}, b_reg};
    prod_u = {32'b0, a_reg} * {32'b0, b_reg};
    prod   = signed_reg ? prod_s : prod_u;
  end

  // Signed division via magnitudes; 0x80000000 / -1 falls out as 0x80000000, rem 0.
  always_comb begin
    a_neg = signed_reg & a_reg[31];
    b_neg = signed_reg & b_reg[31];
    a_mag = a_neg ? (32'd0 - a_reg) : a_reg;
    b_mag = b_neg ? (32'd0 - b_reg) : b_reg;
    b_div = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag = a_mag / b_div;
    r_mag = a_mag % b_div;
    quot  = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem   = a_neg ? (32'd0 - r_mag) : r_mag;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      hi_reg     <= 32'd0;
      lo_reg     <= 32'd0;
      a_reg      <= 32'd0;
      b_reg      <= 32'd0;
      signed_reg <= 1'b0;
      busy_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (Start) begin
            case (MDOp)
              3'b000, 3'b001: begin
                a_reg      <= A;
                b_reg      <= B;
                signed_reg <= ~MDOp[0];
                count_reg  <= CW'(MULT_CYCLES - 1);
                busy_reg   <= 1'b1;
                state_reg  <= MULT;
              end
              3'b010, 3'b011: begin
                a_reg      <= A;
                b_reg      <= B;
                signed_reg <= ~MDOp[0];
                count_reg  <= CW'(DIV_CYCLES - 1);
                busy_reg   <= 1'b1;
                state_reg  <= DIV;
              end
              3'b100:  hi_reg <= A;
              3'b101:  lo_reg <= A;
              default: ;
            endcase
          end
        end
        MULT: begin
          if (count_reg == '0) begin
            hi_reg    <= prod[63:32];
            lo_reg    <= prod[31:0];
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            count_reg <= count_reg - 1'b1;
          end
        end
        DIV: begin
          if (count_reg == '0) begin
            // Divide by zero still takes the full time but leaves HI/LO alone.
            if (b_reg != 32'd0) begin
              hi_reg <= rem;
              lo_reg <= quot;
            end
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            count_reg <= count_reg - 1'b1;
          end
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign Busy = busy_reg;
  assign DOut = HILOSel ? hi_reg : lo_reg;

endmodule
